// File: rtl/jtframe_tilemap_rom.sv
// rtl/jtframe_tilemap_rom.sv - tile ROM fetcher between tilemap and SDRAM arbiter with deadline tracking (option: JTFRAME_TILEROM_BLANK_EN)
module jtframe_tilemap_rom #(
    parameter int AW = 15,
    parameter int DL = 8
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          pxl_cen,
    input  logic [AW-1:0] tm_addr,
    input  logic          tm_cs,
    output logic [31:0]   tm_data,
    output logic [AW-1:0] sdram_addr,
    output logic          sdram_cs,
    input  logic          sdram_ok,
    input  logic [31:0]   sdram_data,
    output logic          late,
    output logic [7:0]    late_cnt
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam logic [3:0] DL_LAST = 4'(DL - 1);

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] last_addr;
    logic          valid;
    logic          pend;
    logic [AW-1:0] pend_addr;
    logic          cs_d;
    logic [3:0]    dl_cnt;
    logic          expired;
    logic [31:0]   data_reg;

    logic          trigger;
    logic          done;
    logic          issue;
    logic [AW-1:0] issue_addr;
    logic          miss;

    // Request detection, completion, next issue and deadline-miss decode.
    // While BUSY, last_addr already holds the in-flight or pending address, so
    // the "nothing valid yet" qualifier only applies from IDLE; otherwise a held
    // address would re-trigger itself until the first read returns.
    always_comb begin
        state_nx   = state;
        trigger    = tm_cs && ((tm_addr != last_addr) || (!valid && state == IDLE));
        done       = (state == BUSY) && sdram_ok && cs_d;
        issue      = ((state == IDLE) && trigger) || (done && (trigger || pend));
        issue_addr = trigger ? tm_addr : pend_addr;
        miss       = (state == BUSY) && !done && pxl_cen && !expired && (dl_cnt == DL_LAST);
        if (issue) begin
            state_nx = BUSY;
        end else if (done) begin
            state_nx = IDLE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // SDRAM request handshake and per-request deadline counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdram_cs   <= 1'b0;
            sdram_addr <= '0;
            cs_d       <= 1'b0;
            dl_cnt     <= 4'd0;
            expired    <= 1'b0;
        end else if (issue) begin
            sdram_cs   <= 1'b1;
            sdram_addr <= issue_addr;
            cs_d       <= 1'b0;
            dl_cnt     <= 4'd0;
            expired    <= 1'b0;
        end else if (done) begin
            sdram_cs <= 1'b0;
            cs_d     <= 1'b0;
        end else begin
            cs_d <= sdram_cs;
            if (state == BUSY && pxl_cen && !expired) begin
                dl_cnt <= dl_cnt + 4'd1;
                if (dl_cnt == DL_LAST) begin
                    expired <= 1'b1;
                end
            end
        end
    end

    // Returned data capture and one-deep newest-wins pending slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg  <= 32'd0;
            valid     <= 1'b0;
            last_addr <= '0;
            pend      <= 1'b0;
            pend_addr <= '0;
        end else begin
            if (trigger) begin
                last_addr <= tm_addr;
            end
            if (done) begin
                data_reg <= sdram_data;
                valid    <= 1'b1;
                pend     <= 1'b0;
            end else if (state == BUSY && trigger) begin
                pend      <= 1'b1;
                pend_addr <= tm_addr;
            end
        end
    end

    // Sticky late flag and saturating miss counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            late     <= 1'b0;
            late_cnt <= 8'd0;
        end else if (miss) begin
            late <= 1'b1;
            if (late_cnt != 8'hFF) begin
                late_cnt <= late_cnt + 8'd1;
            end
        end
    end

`ifdef JTFRAME_TILEROM_BLANK_EN
    assign tm_data = (state == BUSY && expired) ? 32'h0 : data_reg;
`else
    assign tm_data = data_reg;
`endif

endmodule

// File: tb/tb_jtframe_tilemap_rom.sv
// tb/tb_jtframe_tilemap_rom.sv - self-checking bench for jtframe_tilemap_rom
module tb_jtframe_tilemap_rom;

    localparam int AW = 15;
    localparam int DL = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pxl_cen = 1'b0;
    logic [AW-1:0] tm_addr = '0;
    logic          tm_cs = 1'b0;
    logic [31:0]   tm_data;
    logic [AW-1:0] sdram_addr;
    logic          sdram_cs;
    logic          sdram_ok = 1'b0;
    logic [31:0]   sdram_data = 32'd0;
    logic          late;
    logic [7:0]    late_cnt;

    jtframe_tilemap_rom #(.AW(AW), .DL(DL)) dut (
        .rst        (rst),
        .clk        (clk),
        .pxl_cen    (pxl_cen),
        .tm_addr    (tm_addr),
        .tm_cs      (tm_cs),
        .tm_data    (tm_data),
        .sdram_addr (sdram_addr),
        .sdram_cs   (sdram_cs),
        .sdram_ok   (sdram_ok),
        .sdram_data (sdram_data),
        .late       (late),
        .late_cnt   (late_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] fdata(input logic [AW-1:0] a);
        if (a == 15'h0123) return 32'hDEADBEEF;
        return {a[7:0], 1'b0, a, 8'h3C};
    endfunction

    // SDRAM responder and pixel enable, driven just after each rising edge
    int            cen_div = 1;
    bit            resp_en = 1'b1;
    int            resp_delay = 3;
    int            age = 0;
    int            cyc = 0;
    logic          prev_cs = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    bit            real_ok = 1'b0;
    logic [AW-1:0] reads[$];

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (sdram_cs && (!prev_cs || sdram_addr != prev_addr || real_ok)) begin
            age = 0;
            reads.push_back(sdram_addr);
        end else if (sdram_cs) begin
            age++;
        end
        prev_cs   = sdram_cs;
        prev_addr = sdram_addr;
        real_ok   = resp_en && sdram_cs && (age >= resp_delay);
        sdram_ok  = real_ok || (sdram_cs && age == 0);
        sdram_data = real_ok ? fdata(sdram_addr) : (sdram_ok ? 32'h0BADF00D : 32'h0);
        pxl_cen   = (cyc % cen_div) == 0;
    end

    // Transaction-level reference: queue of outstanding reads (front in flight)
    bit            mon_en = 1'b0;
    logic [AW-1:0] q[$];
    logic [AW-1:0] m_last;
    bit            m_valid;
    int            m_age;
    int            m_ticks;
    bit            m_exp;
    bit            m_late;
    int            m_cnt;
    logic [31:0]   m_data;

    task automatic model_reset();
        q.delete();
        m_last = '0; m_valid = 0; m_age = 0; m_ticks = 0;
        m_exp = 0; m_late = 0; m_cnt = 0; m_data = 32'd0;
    endtask

    task automatic model_step();
        bit busy, trig, done;
        busy = q.size() > 0;
        trig = tm_cs && (tm_addr != m_last || (!m_valid && !busy));
        done = busy && sdram_ok && m_age >= 1;
        if (busy && !done && pxl_cen && !m_exp) begin
            m_ticks++;
            if (m_ticks == DL) begin
                m_exp = 1; m_late = 1;
                if (m_cnt < 255) m_cnt++;
            end
        end
        if (busy && !done) m_age++;
        if (trig) m_last = tm_addr;
        if (done) begin
            m_data = sdram_data;
            m_valid = 1;
            void'(q.pop_front());
            if (trig) begin
                q.delete();
                q.push_back(tm_addr);
            end
            if (q.size() > 0) begin
                m_age = 0; m_ticks = 0; m_exp = 0;
            end
        end else if (trig) begin
            if (!busy) begin
                q.push_back(tm_addr);
                m_age = 0; m_ticks = 0; m_exp = 0;
            end else if (q.size() == 1) begin
                q.push_back(tm_addr);
            end else begin
                q[1] = tm_addr;
            end
        end
    endtask

    // Compare DUT against the reference on every falling edge, then advance it
    always @(negedge clk) begin
        if (mon_en) begin
            logic [31:0] exp_data;
            if (rst) model_reset();
`ifdef JTFRAME_TILEROM_BLANK_EN
            exp_data = (q.size() > 0 && m_exp) ? 32'h0 : m_data;
`else
            exp_data = m_data;
`endif
            chk("sdram_cs", sdram_cs, q.size() > 0);
            if (q.size() > 0) chk("sdram_addr", sdram_addr, q[0]);
            chk("tm_data", tm_data, exp_data);
            chk("late", late, m_late);
            chk("late_cnt", late_cnt, m_cnt);
            if (!rst) model_step();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (sdram_cs && n < budget);
        if (sdram_cs) chk({name, "_timeout"}, 1'b1, 1'b0);
    endtask

    logic [31:0] prior;
    int          n0;

    initial begin
        model_reset();
        mon_en = 1'b1;
        step();
        chk("rst_sdram_cs", sdram_cs, 1'b0);
        chk("rst_sdram_addr", sdram_addr, 32'd0);
        chk("rst_tm_data", tm_data, 32'd0);
        chk("rst_late", late, 1'b0);
        chk("rst_late_cnt", late_cnt, 32'd0);
        step();
        rst = 1'b0;
        step();

        // basic read
        reads.delete();
        tm_cs = 1'b1; tm_addr = 15'h0123;
        wait_idle(50, "basic");
        step();
        chk("basic_nreads", reads.size(), 32'd1);
        if (reads.size() > 0) chk("basic_addr", reads[0], 32'h0123);
        chk("basic_data", tm_data, 32'hDEADBEEF);
        chk("basic_late", late, 1'b0);

        // queue overwrite: newest pending wins
        reads.delete();
        resp_delay = 6;
        tm_addr = 15'h10; step(); step();
        tm_addr = 15'h20; step();
        tm_addr = 15'h30; step();
        wait_idle(100, "ovw"); step();
        chk("ovw_nreads", reads.size(), 32'd2);
        if (reads.size() == 2) begin
            chk("ovw_first", reads[0], 32'h10);
            chk("ovw_second", reads[1], 32'h30);
        end
        chk("ovw_data", tm_data, fdata(15'h30));

        // trigger coinciding with completion replaces the older pending address
        reads.delete();
        resp_delay = 3;
        tm_addr = 15'h61; step();
        tm_addr = 15'h62; step(); step(); step();
        tm_addr = 15'h63;
        wait_idle(100, "coinc"); step();
        chk("coinc_nreads", reads.size(), 32'd2);
        if (reads.size() == 2) chk("coinc_second", reads[1], 32'h63);
        chk("coinc_data", tm_data, fdata(15'h63));

        // slow pixel clock: long SDRAM latency still inside the deadline
        cen_div = 4; resp_delay = 12;
        tm_addr = 15'h80;
        wait_idle(100, "slowcen"); step();
        chk("slowcen_late", late, 1'b0);
        chk("slowcen_data", tm_data, fdata(15'h80));

        // deadline miss
        cen_div = 1; resp_en = 1'b0;
        prior = tm_data;
        tm_addr = 15'h40; step();
        repeat (12) step();
        chk("dl_late", late, 1'b1);
        chk("dl_cnt", late_cnt, 32'd1);
`ifdef JTFRAME_TILEROM_BLANK_EN
        chk("dl_blank", tm_data, 32'h0);
`else
        chk("dl_hold", tm_data, prior);
`endif
        resp_en = 1'b1;
        wait_idle(50, "dl"); step();
        chk("dl_data", tm_data, fdata(15'h40));
        chk("dl_cnt_after", late_cnt, 32'd1);

        // blanking: no new requests, in-flight one completes
        resp_delay = 5;
        tm_addr = 15'h50; step(); step();
        tm_cs = 1'b0;
        n0 = reads.size();
        for (int i = 0; i < 100; i++) begin
            tm_addr = 15'(i * 7 + 1);
            step();
        end
        chk("blank_nreads", reads.size(), n0);
        chk("blank_cs", sdram_cs, 1'b0);
        chk("blank_data", tm_data, fdata(15'h50));

        // reset in the middle of a request
        resp_delay = 8;
        tm_cs = 1'b1; tm_addr = 15'h70; step();
        step(); step();
        rst = 1'b1;
        #1;
        chk("rstb_cs", sdram_cs, 1'b0);
        chk("rstb_data", tm_data, 32'd0);
        chk("rstb_cnt", late_cnt, 32'd0);
        reads.delete();
        step();
        rst = 1'b0;
        resp_delay = 3;
        wait_idle(50, "rstb"); step();
        chk("rstb_nreads", reads.size(), 32'd1);
        if (reads.size() > 0) chk("rstb_addr", reads[0], 32'h70);
        chk("rstb_refetch", tm_data, fdata(15'h70));

        // saturation of the miss counter
        resp_delay = 10;
        for (int i = 0; i < 300; i++) begin
            tm_addr = 15'(16'h100 + i);
            wait_idle(40, "sat");
        end
        step();
        chk("sat_cnt", late_cnt, 32'd255);
        chk("sat_late", late, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/jtframe_tilemap_rom.md
JTFRAME_TILEMAP_ROM -- requirements
Module: jtframe_tilemap_rom

Interface
REQ-001 SHALL have parameter AW, default 15: width of tile ROM word address, both sides.
REQ-002 SHALL have parameter DL, default 8: deadline in pxl_cen ticks from request start to data-late declaration; range 2..15.
REQ-003 SHALL have ports `rst` (in, 1) and `clk` (in, 1). Reset is asynchronous and active-high; `clk` is the single clock.
REQ-004 SHALL have port `pxl_cen` (in, 1): pixel clock enable; used only for deadline counting.
REQ-005 SHALL have port `tm_addr` (in, AW): tile ROM address from the tilemap stage.
REQ-006 SHALL have port `tm_cs` (in, 1): tilemap request enable; low during blanking.
REQ-007 SHALL have port `tm_data` (out, 32): pixel data returned to the tilemap, 4 plane bytes.
REQ-008 SHALL have port `sdram_addr` (out, AW): address presented to the SDRAM arbiter.
REQ-009 SHALL have port `sdram_cs` (out, 1): SDRAM request, level-held until served.
REQ-010 SHALL have port `sdram_ok` (in, 1): SDRAM data-valid.
REQ-011 SHALL have port `sdram_data` (in, 32): SDRAM read data.
REQ-012 SHALL have port `late` (out, 1): sticky flag set on any deadline miss.
REQ-013 SHALL have port `late_cnt` (out, 8): saturating count of deadline misses.

Function
REQ-014 SHALL implement FSM states IDLE and BUSY; plus registers last_addr, valid, pend, pend_addr, cs_d, dl_cnt, expired.
REQ-015 Trigger: a new request SHALL be detected in any clk cycle where tm_cs=1 and either tm_addr!=last_addr or valid=0; pxl_cen does not qualify the trigger.
REQ-016 IDLE + trigger: sdram_addr<=tm_addr, last_addr<=tm_addr, sdram_cs<=1, dl_cnt<=0, expired<=0, go to BUSY.
REQ-017 BUSY: sdram_cs SHALL stay high; sdram_ok SHALL be ignored in the first cycle after sdram_cs rises (cs_d=0).
REQ-018 BUSY, sdram_ok=1, cs_d=1: tm_data<=sdram_data, valid<=1, sdram_cs<=0; go to IDLE, or start pend_addr per REQ-016 the same cycle if pend=1, clearing pend.
REQ-019 BUSY + trigger: pend<=1, pend_addr<=tm_addr, last_addr<=tm_addr; a later trigger overwrites pend_addr (depth 1, newest wins); in-flight request SHALL NOT be aborted.
REQ-020 Trigger and completion in the same cycle: completion per REQ-018 first, then the new address is issued immediately, taking priority over the older pend_addr, which is discarded.
REQ-021 tm_cs=0: no new triggers; an in-flight request and any pending request SHALL still complete; valid is unchanged.
REQ-022 Deadline: dl_cnt SHALL increment on pxl_cen while BUSY; on reaching DL with data not yet returned, expired<=1, late<=1, late_cnt+=1 (saturating at 255), once per request.
REQ-023 tm_data SHALL change only on completion (REQ-018); latency from trigger to tm_data update is at least 3 clk cycles.
REQ-024 sdram_addr SHALL be stable whenever sdram_cs=1.

Reset
REQ-025 On rst: sdram_cs=0, sdram_addr=0, tm_data=0, late=0, late_cnt=0, valid=0, pend=0, FSM=IDLE, all immediately (asynchronous).
REQ-026 rst asserted mid-BUSY SHALL drop sdram_cs at once; after release, the first trigger is a fresh request, since valid=0.

Configuration
REQ-027 Macro JTFRAME_TILEROM_BLANK_EN defined: while expired=1 and BUSY, tm_data SHALL read 32'h0, giving transparent pixels; the real data is restored on completion.
REQ-028 Macro JTFRAME_TILEROM_BLANK_EN undefined: tm_data SHALL hold the previous data while late; late and late_cnt behave identically in both builds.

Verification
REQ-029 Basic read: tm_cs=1, tm_addr=0x0123; SDRAM returns 0xDEADBEEF 4 cycles after cs. Required: sdram_addr=0x0123, a single sdram_cs pulse, tm_data=0xDEADBEEF, late=0.
REQ-030 Queue overwrite: addresses 0x10, 0x20, then 0x30 change while BUSY on 0x10. Required: exactly two SDRAM reads, 0x10 then 0x30; tm_data ends equal to data@0x30.
REQ-031 Deadline miss: DL=8 with sdram_ok withheld for 10 pxl_cen. Required: late=1 and late_cnt=1. BLANK_EN build: tm_data=0 from tick 8 until ok. Non-BLANK build: tm_data holds its prior value.
REQ-032 Reset mid-BUSY: assert rst 2 cycles after cs rises. Required: sdram_cs=0 in the same cycle, tm_data=0, late_cnt=0.
REQ-033 Blanking: tm_cs=0 while tm_addr toggles across 100 cycles. Required: no sdram_cs; an in-flight request still completes.
REQ-034 Saturation: 300 forced misses. Required: late_cnt=255.
